// File: rtl/mad_int_controller.sv
// Edge-triggered interrupt controller: pending/mask/priority, fixed-length Int pulse, held vector until IntAck.
// Optional `MAD_INT_SYNC_EN adds a two-flop synchronizer on every Irq line (+2 cycles latency).
module mad_int_controller #(
  parameter int NUM_SRC   = 4,
  parameter int VEC_W     = 2,
  parameter int PULSE_LEN = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_SRC-1:0] Irq,
  input  logic [NUM_SRC-1:0] Mask,
  input  logic               IntAck,
  output logic               Int,
  output logic [VEC_W-1:0]   IntVec,
  output logic [NUM_SRC-1:0] Pending,
  output logic               Busy
);

  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               int_q;
  logic [VEC_W-1:0]   vec_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] irq_s, irq_q, rise, avail, clr;
  logic [VEC_W-1:0]   sel;

`ifdef MAD_INT_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  // Synchronizer keeps sampling through reset so a level held across release is not an edge.
  always_ff @(posedge Clk) begin
    sync1_q <= Irq;
    sync2_q <= sync1_q;
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = Irq;
`endif

  always_ff @(posedge Clk) begin
    irq_q <= irq_s;
  end

  assign rise  = irq_s & ~irq_q;
  assign avail = pending_q & ~Mask;

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (avail[i]) sel = VEC_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state_q == WAIT_ACK && IntAck) clr = NUM_SRC'(1) << vec_q;
  end

  // A fresh edge on the bit being acknowledged survives the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge Clk) begin
    if (Rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|avail) begin
            vec_q   <= sel;
            int_q   <= 1'b1;
            cnt_q   <= CNT_W'(PULSE_LEN - 1);
            state_q <= ASSERT;
          end
        end
        ASSERT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            int_q   <= 1'b0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (IntAck) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Int     = int_q;
  assign IntVec  = vec_q;
  assign Pending = pending_q;
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mad_int_controller.sv
// Scoreboard bench for mad_int_controller: expected vectors queued at stimulus, checked on each Int rise.
module tb_mad_int_controller;

  localparam int PULSE_LEN = 2;
`ifdef MAD_INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Irq = '0;
  logic [3:0] Mask = '0;
  logic       IntAck = 1'b0;
  logic       Int;
  logic [1:0] IntVec;
  logic [3:0] Pending;
  logic       Busy;

  int total = 0;
  int bad   = 0;
  int sb[$];

  mad_int_controller #(.NUM_SRC(4), .VEC_W(2), .PULSE_LEN(PULSE_LEN)) dut (
    .Clk(Clk), .Rst(Rst), .Irq(Irq), .Mask(Mask), .IntAck(IntAck),
    .Int(Int), .IntVec(IntVec), .Pending(Pending), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Wait for a full Int pulse; leaves the DUT in WAIT_ACK.
  task automatic wait_pulse(input string tag);
    int n = 0;
    while (!Int && n < 40) begin tick(); n++; end
    check({tag, "_rise"}, 32'(Int), 1);
    n = 0;
    while (Int && n < 40) begin tick(); n++; end
    check({tag, "_fall"}, 32'(Int), 0);
  endtask

  task automatic ack();
    IntAck = 1'b1;
    tick();
    IntAck = 1'b0;
  endtask

  // Output side of the scoreboard: each Int rise consumes one expected vector.
  logic int_prev = 1'b0;
  int   hi_cnt   = 0;
  always @(negedge Clk) begin
    if (Int && !int_prev) begin
      hi_cnt = 1;
      if (sb.size() == 0) check("int_unexpected", 32'(Int), 0);
      else                check("int_vec", 32'(IntVec), 32'(sb.pop_front()));
    end else if (Int) begin
      hi_cnt++;
    end else if (int_prev) begin
      check("int_len", 32'(hi_cnt), PULSE_LEN);
    end
    int_prev = Int;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single request with exact timing
    tick();
    Rst = 1'b0;
    check("rst_int", 32'(Int), 0);
    check("rst_vec", 32'(IntVec), 0);
    check("rst_pend", 32'(Pending), 0);
    check("rst_busy", 32'(Busy), 0);
    Irq = 4'b0100;
    sb.push_back(2);
    tick();
    repeat (LAT) tick();
    check("s1_pend", 32'(Pending), 4'b0100);
    check("s1_int_early", 32'(Int), 0);
    tick();
    check("s1_int1", 32'(Int), 1);
    check("s1_vec", 32'(IntVec), 2);
    check("s1_busy", 32'(Busy), 1);
    tick();
    check("s1_int2", 32'(Int), 1);
    tick();
    check("s1_int_off", 32'(Int), 0);
    check("s1_busy_wait", 32'(Busy), 1);
    tick();
    ack();
    check("s1_pend_clr", 32'(Pending), 0);
    check("s1_busy_clr", 32'(Busy), 0);

    // Priority: bits 1 and 3 rise together
    Irq = 4'b0000;
    tick();
    Irq = 4'b1010;
    sb.push_back(1);
    sb.push_back(3);
    wait_pulse("s2a");
    ack();
    check("s2_pend_left", 32'(Pending), 4'b1000);
    check("s2_busy_clr", 32'(Busy), 0);
    tick();
    check("s2_second_int", 32'(Int), 1);
    check("s2_second_vec", 32'(IntVec), 3);
    wait_pulse("s2b");
    ack();
    check("s2_pend_done", 32'(Pending), 0);

    // Mask holds back a pending source
    Mask = 4'b0001;
    Irq  = 4'b0001;
    sb.push_back(0);
    tick();
    repeat (LAT) tick();
    check("s3_pend", 32'(Pending), 4'b0001);
    tick();
    tick();
    check("s3_masked_int", 32'(Int), 0);
    check("s3_masked_busy", 32'(Busy), 0);
    Mask = 4'b0000;
    tick();
    check("s3_unmask_int", 32'(Int), 1);
    wait_pulse("s3");
    ack();
    check("s3_pend_done", 32'(Pending), 0);

    // Spurious ack in IDLE, early ack in ASSERT
    Mask = 4'b1111;
    Irq  = 4'b0100;
    tick();
    repeat (LAT) tick();
    check("s4_pend", 32'(Pending), 4'b0100);
    ack();
    check("s4_idle_ack_pend", 32'(Pending), 4'b0100);
    check("s4_idle_ack_busy", 32'(Busy), 0);
    Mask = 4'b0000;
    sb.push_back(2);
    tick();
    check("s4_assert_int", 32'(Int), 1);
    ack();
    check("s4_early_ack_int", 32'(Int), 1);
    check("s4_early_ack_pend", 32'(Pending), 4'b0100);
    tick();
    check("s4_wait_int", 32'(Int), 0);
    check("s4_wait_busy", 32'(Busy), 1);
    check("s4_wait_pend", 32'(Pending), 4'b0100);
    ack();
    check("s4_pend_done", 32'(Pending), 0);
    check("s4_busy_done", 32'(Busy), 0);

    // New edge collides with the ack of the same vector: set wins
    Irq = 4'b0000;
    tick();
    Irq = 4'b0010;
    sb.push_back(1);
    wait_pulse("s5a");
    Irq = 4'b0000;
    tick();
    Irq = 4'b0010;
    repeat (LAT) tick();
    sb.push_back(1);
    ack();
    check("s5_setwins_pend", 32'(Pending), 4'b0010);
    check("s5_setwins_busy", 32'(Busy), 0);
    tick();
    check("s5_reserve_int", 32'(Int), 1);
    check("s5_reserve_vec", 32'(IntVec), 1);
    wait_pulse("s5b");
    ack();
    check("s5_pend_done", 32'(Pending), 0);

    // Reset while waiting for ack
    Irq = 4'b0000;
    repeat (LAT + 1) tick();
    Irq = 4'b1001;
    sb.push_back(0);
    wait_pulse("s6");
    check("s6_pend_before", 32'(Pending), 4'b1001);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("s6_rst_int", 32'(Int), 0);
    check("s6_rst_vec", 32'(IntVec), 0);
    check("s6_rst_pend", 32'(Pending), 0);
    check("s6_rst_busy", 32'(Busy), 0);
    repeat (LAT + 3) tick();
    check("s6_post_pend", 32'(Pending), 0);
    check("s6_post_int", 32'(Int), 0);

    check("sb_left", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
